// File: rtl/led_sweeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_sweeper_pkg
//  Description : Shared types and width helper for the LED sweep controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_sweeper_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE  = 2'd0,
    MODE_WRAP    = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_HOLD    = 2'd3
  } sweep_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } oneshot_state_t;

  // Width of the position output; never less than one bit.
  function automatic int pos_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_sweeper_step_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : step_prescaler
//  Description : Free-running step divider with synchronous clear. Pulses
//                o_step in the cycle the count sits at DIV-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module step_prescaler #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_step
);

  localparam int              CW     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("step_prescaler: DIV must be >= 2");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_step = i_en && (cnt_q == C_LAST);

  // Next count: clear beats wrap, wrap beats increment, disabled holds.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (o_step) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : led_sweeper
//  Description : One-hot LED sweep controller with bounce, wrap, one-shot and
//                hold modes. Optional trailing LED when LED_SWEEPER_TRAIL_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_sweeper
  import led_sweeper_pkg::*;
#(
  parameter int NLEDS    = 7,
  parameter int STEP_DIV = 25_000_000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_run,
  input  logic [1:0]                   i_mode,
  input  logic                         i_start,
  output logic [NLEDS-1:0]             o_led,
  output logic [pos_width(NLEDS)-1:0]  o_pos,
  output logic                         o_dir,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int                PW     = pos_width(NLEDS);
  localparam logic [PW-1:0]     C_LAST = PW'(NLEDS - 1);
  localparam logic [PW-1:0]     C_ONE  = PW'(1);
  localparam logic [NLEDS-1:0]  C_BIT0 = NLEDS'(1);

  if (NLEDS < 2) begin : g_bad_nleds
    $error("led_sweeper: NLEDS must be >= 2");
  end

  sweep_mode_t     w_mode;
  logic            w_step;
  logic            w_start;
  logic            w_moved;

  logic [PW-1:0]   pos_q,   pos_d;
  logic            dir_q,   dir_d;
  oneshot_state_t  state_q, state_d;
  logic            done_q,  done_d;
  logic [NLEDS-1:0] led_q,  led_d;

  assign w_mode  = sweep_mode_t'(i_mode);
  assign w_start = i_run && (w_mode == MODE_ONESHOT) && (state_q == ST_IDLE) && i_start;

  step_prescaler #(
    .DIV (STEP_DIV)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_run),
    .i_clr   (w_start),
    .o_step  (w_step)
  );

  // Next position/direction/handshake; a start consumes any coincident step.
  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    state_d = state_q;
    done_d  = 1'b0;
    w_moved = 1'b0;
    if (w_start) begin
      state_d = ST_BUSY;
      pos_d   = '0;
      dir_d   = 1'b1;
    end else if (i_run) begin
      if ((state_q == ST_BUSY) && (w_mode != MODE_ONESHOT)) begin
        state_d = ST_IDLE;
      end
      if (w_step) begin
        case (w_mode)
          MODE_BOUNCE, MODE_ONESHOT: begin
            if ((w_mode == MODE_ONESHOT) && (state_q == ST_IDLE)) begin
              pos_d = '0;
              dir_d = 1'b1;
            end else if (dir_q) begin
              if (pos_q == C_LAST) begin
                pos_d = C_LAST - 1'b1;
                dir_d = 1'b0;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = C_ONE;
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q - 1'b1;
              end
              // Arriving back at zero closes a one-shot sweep.
              if ((w_mode == MODE_ONESHOT) && (pos_q == C_ONE)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
          end
          MODE_WRAP: begin
            dir_d = 1'b1;
            pos_d = (pos_q == C_LAST) ? '0 : pos_q + 1'b1;
          end
          MODE_HOLD: begin
          end
          default: begin
          end
        endcase
        w_moved = (pos_d != pos_q);
      end
    end
  end

`ifdef LED_SWEEPER_TRAIL_EN
  logic [PW-1:0] prev_q;
  logic [PW-1:0] prev_d;

  assign prev_d = w_moved ? pos_q : prev_q;
  assign led_d  = (C_BIT0 << pos_d) | (C_BIT0 << prev_d);

  // Trailing position remembers where the light was before each move.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end
`else
  assign led_d = C_BIT0 << pos_d;
`endif

  // All outputs are registered together so LEDs track position with no lag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_q   <= '0;
      dir_q   <= 1'b1;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      led_q   <= C_BIT0;
    end else begin
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      state_q <= state_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign o_led  = led_q;
  assign o_pos  = pos_q;
  assign o_dir  = dir_q;
  assign o_busy = (state_q == ST_BUSY);
  assign o_done = done_q;

endmodule
`default_nettype wire

// File: doc/led_sweeper.md
# led_sweeper

Parametrised LED sweep controller for the board status LEDs. It drives a one-hot light across `NLEDS` outputs at a rate set by an internal step prescaler. It supports bounce, wrap, one-shot (start/busy/done handshake) and hold modes, and can also light a trailing LED. It sits at the top level of the board design between the system clock and the LED pins. It replaces the fixed 7-LED bounce walker.

## Interface

Parameters:
- `NLEDS`, default 7: number of LEDs; must be ≥ 2 (elaboration-time check).
- `STEP_DIV`, default 25_000_000: clock cycles per step; must be ≥ 2.

Ports:
- `i_clk`, in, 1: system clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_run`, in, 1: 1 = prescaler counts; 0 = freeze all state.
- `i_mode`, in, 2: 0 BOUNCE, 1 WRAP, 2 ONESHOT, 3 HOLD.
- `i_start`, in, 1: one-shot request; level-sampled every cycle.
- `o_led`, out, `NLEDS`: LED drive, active-high.
- `o_pos`, out, `$clog2(NLEDS)`: current lit position.
- `o_dir`, out, 1: 1 = moving toward `NLEDS-1`.
- `o_busy`, out, 1: a one-shot sweep is in progress.
- `o_done`, out, 1: one-cycle pulse when a one-shot sweep completes.

## Operation

- **Reset values:** `pos`=0, `dir`=1, `o_led`=1, `o_busy`=0, `o_done`=0, prescaler count=0.
- **Prescaler:** counts 0..`STEP_DIV-1` while `i_run`=1. `step` is high in the cycle where count=`STEP_DIV-1`; the count then wraps to 0. `i_run`=0 holds the count.
- **Mode sampling:** `i_mode` is sampled at every `step`, except for the immediate effects defined for ONESHOT below.
- **BOUNCE:**
  - With `dir`=1: `pos`+1. At `NLEDS-1` the direction reverses: `dir`←0, `pos`←`NLEDS-2`.
  - With `dir`=0: `pos`−1. At 0 the direction reverses: `dir`←1, `pos`←1.
  - The period is 2·(`NLEDS`−1) steps.
- **WRAP:** `dir`←1 and `pos`←`pos`+1. After `NLEDS-1` the next position is 0. A step taken while `dir`=0 still moves `pos`+1.
- **HOLD:** `pos` and `dir` are unchanged. The prescaler keeps running.
- **ONESHOT while idle (`o_busy`=0):** each step sets `pos`←0, `dir`←1.
- **One-shot start:** accepted in any cycle where `i_mode`=ONESHOT, `o_busy`=0 and `i_start`=1.
  - `o_busy`←1 on the next edge and the prescaler count clears to 0.
  - The sweep then follows the BOUNCE path from `pos` 0 for 2·(`NLEDS`−1) steps.
  - On the step that returns `pos` to 0, `o_busy`←0 and `o_done`←1 for exactly one cycle.
- **`i_start` while busy, or in another mode:** ignored.
- **Mode leaves ONESHOT while busy:** `o_busy` clears on the next edge, with no `o_done`; `pos` and `dir` are kept.
- **LED output:** `o_led` = 1<<`pos` (one-hot) unless the trail feature is compiled in.

## Timing

- `o_led`, `o_pos`, `o_dir`, `o_busy` and `o_done` are all registered and update on the same edge as the `step` that moves `pos`. There is zero added latency between position and LED.
- After reset release, the first step edge occurs `STEP_DIV` cycles after the first clock edge with `i_run`=1.
- After an accepted `i_start`, the first step edge occurs `STEP_DIV`+1 cycles after the start cycle. `o_done` rises 2·(`NLEDS`−1)·`STEP_DIV`+1 cycles after the start cycle.
- **`i_start` coinciding with a step:** the start wins; the step is consumed with no movement and the count clears.
- **`i_run`=0 mid-sweep:** all outputs hold and the remaining step count is preserved. `o_done` stays as registered and still pulses only one cycle.
- **Asynchronous reset mid-operation:** all outputs go to their reset values immediately, without a clock edge.

## Configuration

- **Macro `LED_SWEEPER_TRAIL_EN`, defined:** a `prev_pos` register is added. It takes the old `pos` on every step that moves `pos` and resets to 0. `o_led` = (1<<`pos`) | (1<<`prev_pos`).
- **Macro undefined:** `o_led` is strictly one-hot and no `prev_pos` logic exists.

## Structure

- **Package `led_sweeper_pkg`:**
  - `typedef enum logic [1:0] sweep_mode_t` with MODE_BOUNCE, MODE_WRAP, MODE_ONESHOT, MODE_HOLD.
  - The width helper for `o_pos`.
- **Sub-module `step_prescaler`** (parameter `DIV`; ports `i_clk`, `i_rst_n`, `i_en`, `i_clr`, `o_step`). It is separate from the existing divider because it needs a clear input.

## Test plan

All scenarios use `NLEDS`=7, `STEP_DIV`=4, `i_run`=1 unless stated.

- **Reset, then BOUNCE:** `o_led` steps 0x01,0x02,…,0x40,0x20,…,0x02,0x01 with 4 cycles per value. The period is 48 cycles and `o_dir` flips at 0x40 and at 0x01.
- **WRAP:** `o_led` steps 0x01…0x40 then 0x01, period 28 cycles. Switching from BOUNCE at `pos`=5 with `dir`=0 gives next `pos`=6.
- **ONESHOT, single `i_start` pulse:** `o_busy`=1 on the next edge. `o_done` pulses one cycle exactly 49 cycles after the start cycle, with `o_led`=0x01. A second `i_start` while busy is ignored.
- **`i_run`=0 for 10 cycles at `pos`=3 of a one-shot:** all outputs frozen. `o_done` arrives 10 cycles later than in the previous scenario.
- **`i_rst_n` low asynchronously at `pos`=4 while busy:** `o_led`=0x01, `o_busy`=0 and `o_pos`=0 before the next clock edge.
- **With `LED_SWEEPER_TRAIL_EN`, BOUNCE from reset:** `o_led` steps 0x03,0x06,0x0C,0x18,0x30,0x60,0x60,0x30.
